pht_update_ctrl: RTL and testbench



---
 rtl/bp_pkg.sv | 29 ++
 rtl/bp_sync_fifo.sv | 55 +++++
 rtl/pht_update_ctrl.sv | 156 +++++++++++++++
 tb/tb_pht_update_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Branch-predictor shared definitions: 2-bit gray-coded counter encoding,
// saturating update rule and the PHT controller FSM state type.
package bp_pkg;

    localparam int GHR_LENGTH_DEF = 8;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b11;
    localparam logic [1:0] ST  = 2'b10;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } phtState_e;

    // Gray encoding keeps each step a single-bit change.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        case (cnt)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            default: nxt = taken ? ST  : WT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bp_sync_fifo.sv
// Small synchronous FIFO with occupancy count and a synchronous clear;
// storage is not reset, only the pointers and count.
module bp_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rdPtr;
    logic [AW-1:0]    wrPtr;
    logic             doPush;
    logic             doPop;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    // A pop in the same cycle frees the slot the push needs.
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);
    assign dout   = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (rst | clr) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= din;
    end

endmodule

// File: rtl/pht_update_ctrl.sv
// PHT write-port owner: init sweep after reset/clear, queued M-stage updates,
// and a two-stage read-modify-write against a synchronous-read counter RAM.
module pht_update_ctrl
    import bp_pkg::*;
#(
    parameter int         GHR_LENGTH = GHR_LENGTH_DEF,
    parameter int         QDEPTH     = 4,
    parameter logic [1:0] INIT_VAL   = WT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_req,
    input  logic                     upd_valid,
    input  logic [GHR_LENGTH-1:0]    upd_idx,
    input  logic                     upd_taken,
    output logic                     upd_ready,
    output logic                     pht_rd_en,
    output logic [GHR_LENGTH-1:0]    pht_rd_idx,
    input  logic [1:0]               pht_rd_data,
    output logic                     pht_we,
    output logic [GHR_LENGTH-1:0]    pht_wa,
    output logic [1:0]               pht_wd,
    output logic                     init_busy,
    output logic [$clog2(QDEPTH):0]  q_count
);

    localparam int EW = GHR_LENGTH + 1;
    localparam logic [GHR_LENGTH-1:0] LAST_IDX = '1;

    phtState_e state;
    phtState_e stateNext;
    logic [GHR_LENGTH-1:0] cnt;
    logic [GHR_LENGTH-1:0] cntNext;
    logic initWe;

    logic          fifoPush;
    logic          fifoPop;
    logic          fifoFull;
    logic          fifoEmpty;
    logic [EW-1:0] fifoDin;
    logic [EW-1:0] fifoDout;

    logic                  vld_p1;
    logic [GHR_LENGTH-1:0] idx_p1;
    logic                  taken_p1;
    logic                  vld_p2;
    logic [GHR_LENGTH-1:0] wrIdx_p2;
    logic [1:0]            wrData_p2;

    logic       bypassHit;
    logic [1:0] oldCnt;
    logic [1:0] newCnt;

    assign fifoDin  = {upd_idx, upd_taken};
    assign fifoPop  = (state == RUN) & ~fifoEmpty & ~clr_req & ~rst;
    assign fifoPush = upd_valid & upd_ready & ~clr_req;
    assign upd_ready = ~fifoFull | fifoPop;

    bp_sync_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (EW)
    ) updQueue (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_req),
        .push  (fifoPush),
        .pop   (fifoPop),
        .din   (fifoDin),
        .dout  (fifoDout),
        .count (q_count),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        initWe    = 1'b0;
        case (state)
            INIT: begin
                initWe  = 1'b1;
                cntNext = cnt + GHR_LENGTH'(1);
                if (cnt == LAST_IDX) stateNext = RUN;
            end
            RUN:     stateNext = RUN;
            default: stateNext = INIT;
        endcase
        if (clr_req) begin
            stateNext = INIT;
            cntNext   = '0;
        end
    end

    // Stage 1: queue head becomes the RAM read and is captured for stage 2
    assign pht_rd_en  = fifoPop;
    assign pht_rd_idx = fifoPop ? fifoDout[EW-1:1] : '0;

    always_ff @(posedge clk) begin
        if (rst | clr_req) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= fifoPop;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (fifoPop) begin
            idx_p1   <= fifoDout[EW-1:1];
            taken_p1 <= fifoDout[0];
        end
    end

    // Stage 2: RAM reads return pre-write data, so a write to the same index
    // one cycle earlier must be forwarded in place of the RAM output.
    assign bypassHit = vld_p2 & (wrIdx_p2 == idx_p1);
    assign oldCnt    = bypassHit ? wrData_p2 : pht_rd_data;
    assign newCnt    = sat_update(oldCnt, taken_p1);

    always_ff @(posedge clk) begin
        if (vld_p1) begin
            wrIdx_p2  <= idx_p1;
            wrData_p2 <= newCnt;
        end
    end

    always_comb begin
        pht_we    = 1'b0;
        pht_wa    = '0;
        pht_wd    = '0;
        init_busy = rst | (state == INIT);
        if (!rst) begin
            if (initWe) begin
                pht_we = 1'b1;
                pht_wa = cnt;
                pht_wd = INIT_VAL;
            end else if (vld_p1 && !clr_req) begin
                pht_we = 1'b1;
                pht_wa = idx_p1;
                pht_wd = newCnt;
            end
        end
    end

endmodule

// File: tb/tb_pht_update_ctrl.sv
// Bench for pht_update_ctrl: behavioural PHT RAM plus a queue/array model of
// the update controller, directed scenarios and a randomized run.
module tb_pht_update_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr_req;
    logic       upd_valid;
    logic [7:0] upd_idx;
    logic       upd_taken;
    logic       upd_ready;
    logic       pht_rd_en;
    logic [7:0] pht_rd_idx;
    logic [1:0] pht_rd_data;
    logic       pht_we;
    logic [7:0] pht_wa;
    logic [1:0] pht_wd;
    logic       init_busy;
    logic [2:0] q_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pht_update_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .clr_req     (clr_req),
        .upd_valid   (upd_valid),
        .upd_idx     (upd_idx),
        .upd_taken   (upd_taken),
        .upd_ready   (upd_ready),
        .pht_rd_en   (pht_rd_en),
        .pht_rd_idx  (pht_rd_idx),
        .pht_rd_data (pht_rd_data),
        .pht_we      (pht_we),
        .pht_wa      (pht_wa),
        .pht_wd      (pht_wd),
        .init_busy   (init_busy),
        .q_count     (q_count)
    );

    // Synchronous-read RAM, read-before-write on a same-address collision
    logic [1:0] ram [256];
    logic [1:0] rdq = 2'b00;
    assign pht_rd_data = rdq;
    initial for (int i = 0; i < 256; i++) ram[i] = 2'b00;
    always @(posedge clk) begin
        if (pht_rd_en) rdq <= ram[pht_rd_idx];
        if (pht_we)    ram[pht_wa] <= pht_wd;
    end

    // Reference model: counters as levels 0..3 (SNT..ST), FIFO as a queue
    typedef struct { int idx; bit taken; } upd_t;
    typedef struct packed {
        logic       we;
        logic [7:0] wa;
        logic [1:0] wd;
        logic       rdEn;
        logic [7:0] rdIdx;
        logic       ready;
        logic [2:0] qc;
        logic       busy;
    } exp_t;

    bit   mInit = 1'b1;
    int   mSweep = 0;
    upd_t mQ[$];
    int   mPht [256];
    bit   mStageV = 1'b0;
    int   mStageIdx = 0;
    int   mStageLvl = 0;
    initial for (int i = 0; i < 256; i++) mPht[i] = 0;

    function automatic logic [1:0] enc(input int lvl);
        case (lvl)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    always @(posedge clk) begin : model_b
        upd_t e;
        bit   pop;
        bit   acc;
        int   lvl;
        if (rst || clr_req) begin
            mInit = 1'b1;
            mSweep = 0;
            mQ.delete();
            mStageV = 1'b0;
        end else begin
            pop = !mInit && (mQ.size() > 0);
            acc = upd_valid && ((mQ.size() < 4) || pop);
            if (mInit) begin
                mPht[mSweep] = 2;
                mSweep++;
                if (mSweep == 256) mInit = 1'b0;
            end
            mStageV = 1'b0;
            if (pop) begin
                e = mQ.pop_front();
                lvl = mPht[e.idx];
                lvl = e.taken ? ((lvl < 3) ? lvl + 1 : 3) : ((lvl > 0) ? lvl - 1 : 0);
                mPht[e.idx] = lvl;
                mStageV = 1'b1;
                mStageIdx = e.idx;
                mStageLvl = lvl;
            end
            if (acc) begin
                e.idx = int'(upd_idx);
                e.taken = upd_taken;
                mQ.push_back(e);
            end
        end
    end

    function automatic exp_t calcExp();
        exp_t e;
        bit pop;
        e = '0;
        pop = !mInit && (mQ.size() > 0) && !clr_req;
        e.busy = mInit;
        if (mInit) begin
            e.we = 1'b1; e.wa = 8'(mSweep); e.wd = 2'b11;
        end else if (mStageV && !clr_req) begin
            e.we = 1'b1; e.wa = 8'(mStageIdx); e.wd = enc(mStageLvl);
        end
        e.rdEn = pop;
        if (pop) e.rdIdx = 8'(mQ[0].idx);
        e.ready = (mQ.size() < 4) || pop;
        e.qc = 3'(mQ.size());
        return e;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr_req = 1'b0; upd_valid = 1'b0; upd_idx = 8'd0; upd_taken = 1'b0;
        cyc(); cyc();
        @(negedge clk);
        checks++; if (pht_we !== 1'b0)    begin errors++; $display("FAIL reset_we got %0b want 0", pht_we); end
        checks++; if (pht_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %0b want 0", pht_rd_en); end
        checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %0b want 1", init_busy); end
        checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", upd_ready); end
        checks++; if (q_count !== 3'd0)   begin errors++; $display("FAIL reset_qcount got %0d want 0", q_count); end
        checks++; if ({pht_wa, pht_wd, pht_rd_idx} !== 18'd0)
            begin errors++; $display("FAIL reset_addr_data got %0h/%0h/%0h want 0", pht_wa, pht_wd, pht_rd_idx); end
        cyc();
    endtask

    task automatic test_init_sweep();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            checks++;
            if (pht_we !== 1'b1 || pht_wa !== 8'(i) || pht_wd !== 2'b11 || init_busy !== 1'b1) begin
                errors++;
                $display("FAIL sweep_%0d got we=%0b wa=%0d wd=%0b busy=%0b want 1/%0d/11/1", i, pht_we, pht_wa, pht_wd, init_busy, i);
            end
            cyc();
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (init_busy !== 1'b0 || pht_we !== 1'b0) begin
                errors++;
                $display("FAIL post_sweep_%0d got busy=%0b we=%0b want 0/0", i, init_busy, pht_we);
            end
            cyc();
        end
    endtask

    task automatic test_run_basic();
        upd_valid = 1'b1; upd_idx = 8'd5; upd_taken = 1'b1;
        @(negedge clk);
        checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %0b want 1", upd_ready); end
        cyc();
        upd_valid = 1'b0;
        @(negedge clk);
        checks++; if (q_count !== 3'd1) begin errors++; $display("FAIL basic_qcount got %0d want 1", q_count); end
        checks++; if (pht_rd_en !== 1'b1 || pht_rd_idx !== 8'd5)
            begin errors++; $display("FAIL basic_read got en=%0b idx=%0d want 1/5", pht_rd_en, pht_rd_idx); end
        checks++; if (pht_we !== 1'b0) begin errors++; $display("FAIL basic_early_we got %0b want 0", pht_we); end
        cyc();
        @(negedge clk);
        checks++; if (pht_we !== 1'b1 || pht_wa !== 8'd5 || pht_wd !== 2'b10)
            begin errors++; $display("FAIL basic_write got we=%0b wa=%0d wd=%0b want 1/5/10", pht_we, pht_wa, pht_wd); end
        cyc();
        @(negedge clk);
        checks++; if (pht_we !== 1'b0 || q_count !== 3'd0)
            begin errors++; $display("FAIL basic_idle got we=%0b q=%0d want 0/0", pht_we, q_count); end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [1:0] wds[$];
        logic [7:0] was[$];
        logic [1:0] expWd [4];
        expWd = '{2'b01, 2'b11, 2'b10, 2'b10};
        for (int c = 0; c < 10; c++) begin
            upd_valid = (c == 0) || (c >= 3 && c <= 5);
            upd_idx = 8'd7;
            upd_taken = (c >= 3);
            @(negedge clk);
            if (pht_we) begin wds.push_back(pht_wd); was.push_back(pht_wa); end
            cyc();
        end
        upd_valid = 1'b0;
        checks++; if (wds.size() != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", wds.size()); end
        for (int j = 0; j < 4 && j < wds.size(); j++) begin
            checks++;
            if (wds[j] !== expWd[j] || was[j] !== 8'd7) begin
                errors++;
                $display("FAIL b2b_write%0d got wa=%0d wd=%0b want 7/%0b", j, was[j], wds[j], expWd[j]);
            end
        end
    endtask

    task automatic test_st_not_taken();
        logic [1:0] wds[$];
        logic [1:0] expWd [3];
        expWd = '{2'b10, 2'b11, 2'b01};
        for (int c = 0; c < 9; c++) begin
            upd_valid = (c == 0) || (c == 3) || (c == 4);
            upd_idx = 8'd9;
            upd_taken = (c == 0);
            @(negedge clk);
            if (pht_we && pht_wa == 8'd9) wds.push_back(pht_wd);
            cyc();
        end
        upd_valid = 1'b0;
        checks++; if (wds.size() != 3) begin errors++; $display("FAIL st_nt_count got %0d want 3", wds.size()); end
        for (int j = 0; j < 3 && j < wds.size(); j++) begin
            checks++;
            if (wds[j] !== expWd[j]) begin
                errors++; $display("FAIL st_nt_write%0d got %0b want %0b", j, wds[j], expWd[j]);
            end
        end
    endtask

    task automatic test_queue_full_init();
        int lastSweep = -1;
        int rmwCyc[$];
        logic [7:0] rmwWa[$];
        logic [1:0] rmwWd[$];
        logic [1:0] expWd [4];
        expWd = '{2'b01, 2'b10, 2'b01, 2'b10};
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            upd_valid = 1'b1; upd_idx = 8'(20 + k); upd_taken = k[0];
            @(negedge clk);
            checks++;
            if (upd_ready !== (k < 4)) begin
                errors++; $display("FAIL qfull_ready%0d got %0b want %0b", k, upd_ready, (k < 4));
            end
            cyc();
        end
        upd_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (q_count !== 3'd4 || init_busy !== 1'b1) begin
                    errors++; $display("FAIL qfull_count got q=%0d busy=%0b want 4/1", q_count, init_busy);
                end
            end
            if (pht_we && init_busy && pht_wa == 8'd255) lastSweep = i;
            if (pht_we && !init_busy) begin rmwCyc.push_back(i); rmwWa.push_back(pht_wa); rmwWd.push_back(pht_wd); end
            cyc();
        end
        checks++; if (lastSweep < 0) begin errors++; $display("FAIL qfull_sweep_end got none want index 255 write"); end
        checks++; if (rmwCyc.size() != 4) begin errors++; $display("FAIL qfull_drain_count got %0d want 4", rmwCyc.size()); end
        for (int j = 0; j < 4 && j < rmwCyc.size(); j++) begin
            checks++;
            if (rmwCyc[j] != lastSweep + 2 + j || rmwWa[j] !== 8'(20 + j) || rmwWd[j] !== expWd[j]) begin
                errors++;
                $display("FAIL qfull_drain%0d got cyc=%0d wa=%0d wd=%0b want %0d/%0d/%0b",
                         j, rmwCyc[j], rmwWa[j], rmwWd[j], lastSweep + 2 + j, 20 + j, expWd[j]);
            end
        end
    endtask

    task automatic test_clr_mid_run();
        bit found = 1'b0;
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            upd_valid = 1'b1; upd_idx = 8'(30 + k); upd_taken = 1'b1;
            cyc();
        end
        upd_valid = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (!init_busy) found = 1'b1;
            else cyc();
        end
        checks++; if (!found) begin errors++; $display("FAIL clr_reach_run got busy=1 want 0"); end
        checks++; if (q_count !== 3'd3) begin errors++; $display("FAIL clr_pre_qcount got %0d want 3", q_count); end
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        @(negedge clk);
        checks++; if (q_count !== 3'd0 || init_busy !== 1'b1)
            begin errors++; $display("FAIL clr_state got q=%0d busy=%0b want 0/1", q_count, init_busy); end
        for (int i = 0; i < 256; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (pht_we !== 1'b1 || pht_wa !== 8'(i) || pht_wd !== 2'b11) begin
                errors++; $display("FAIL clr_sweep_%0d got we=%0b wa=%0d wd=%0b want 1/%0d/11", i, pht_we, pht_wa, pht_wd, i);
            end
            cyc();
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (pht_we !== 1'b0 || init_busy !== 1'b0 || pht_rd_en !== 1'b0) begin
                errors++; $display("FAIL clr_discard_%0d got we=%0b busy=%0b rd=%0b want 0/0/0", i, pht_we, init_busy, pht_rd_en);
            end
            cyc();
        end
    endtask

    task automatic test_random();
        exp_t e;
        for (int c = 0; c < 900; c++) begin
            upd_valid = ($urandom_range(9) < 7);
            upd_idx   = 8'($urandom_range(7));
            upd_taken = $urandom_range(1) == 1;
            clr_req   = ($urandom_range(349) == 0);
            @(negedge clk);
            e = calcExp();
            checks++;
            if (pht_we !== e.we || pht_wa !== e.wa || pht_wd !== e.wd) begin
                errors++; $display("FAIL rnd_write c%0d got %0b/%0d/%0b want %0b/%0d/%0b", c, pht_we, pht_wa, pht_wd, e.we, e.wa, e.wd);
            end
            checks++;
            if (pht_rd_en !== e.rdEn || pht_rd_idx !== e.rdIdx) begin
                errors++; $display("FAIL rnd_read c%0d got %0b/%0d want %0b/%0d", c, pht_rd_en, pht_rd_idx, e.rdEn, e.rdIdx);
            end
            checks++;
            if (upd_ready !== e.ready || q_count !== e.qc || init_busy !== e.busy) begin
                errors++; $display("FAIL rnd_ctrl c%0d got rdy=%0b q=%0d busy=%0b want %0b/%0d/%0b",
                                   c, upd_ready, q_count, init_busy, e.ready, e.qc, e.busy);
            end
            cyc();
        end
        upd_valid = 1'b0;
        clr_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_run_basic();
        test_back_to_back();
        test_st_not_taken();
        test_queue_full_init();
        test_clr_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
